// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the 8-bit core's instruction memory.
// Accepts a framed byte stream (LEN, 2*LEN data bytes high byte first, CSUM) over a
// valid/ready handshake, writes each assembled 16-bit word to consecutive addresses
// from 0, and releases the core from reset only after an error-free frame.
//
// Ports:
//   clka        - system clock, rising edge
//   reset       - synchronous active-high reset
//   start       - one-cycle load request, honoured in IDLE/DONE/ERR
//   byte_in     - host data byte
//   byte_valid  - byte_in is valid
//   byte_ready  - loader takes byte_in this cycle
//   we_ins      - instruction-memory write strobe, one cycle per word
//   load        - instruction word to write
//   ins_addr    - write address for load
//   cpu_reset   - holds the core in reset while high
//   done        - frame loaded and checksum matched
//   err         - frame rejected
module prog_loader #(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned MAX_WORDS = 64
) (
   input  logic              clka,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              we_ins,
   output logic [15:0]       load,
   output logic [ADDR_W-1:0] ins_addr,
   output logic              cpu_reset,
   output logic              done,
   output logic              err
);

   // Wide enough to hold the word count N itself (1..MAX_WORDS).
   localparam int unsigned CntW = $clog2(MAX_WORDS + 1);

   typedef enum logic [2:0] {
      StIdle, StLen, StHi, StLo, StWrite, StCsum, StDone, StErr
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   len_q, len_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        acc_q, acc_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       load_q, load_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      hi_d        = hi_q;
      load_d      = load_q;
      addr_d      = addr_q;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
      err_d       = err_q;
      byte_ready  = 1'b0;
      we_ins      = 1'b0;

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d     = StLen;
               acc_d       = '0;
               cnt_d       = '0;
               cpu_reset_d = 1'b1;
               done_d      = 1'b0;
               err_d       = 1'b0;
            end
         end
         StLen: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if (byte_in == 8'd0 || 32'(byte_in) > MAX_WORDS) begin
                  state_d = StErr;
                  err_d   = 1'b1;
               end else begin
                  len_d   = CntW'(byte_in);
                  acc_d   = byte_in;
                  state_d = StHi;
               end
            end
         end
         StHi: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               // High byte is staged so load only changes when a full word is ready.
               hi_d    = byte_in;
               acc_d   = acc_q ^ byte_in;
               state_d = StLo;
            end
         end
         StLo: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               load_d  = {hi_q, byte_in};
               addr_d  = ADDR_W'(cnt_q);
               acc_d   = acc_q ^ byte_in;
               state_d = StWrite;
            end
         end
         StWrite: begin
            we_ins = 1'b1;
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == len_q - CntW'(1)) begin
               state_d = StCsum;
            end else begin
               state_d = StHi;
            end
         end
         StCsum: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if (byte_in == acc_q) begin
                  state_d     = StDone;
                  cpu_reset_d = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  state_d = StErr;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clka) begin
      if (reset) begin
         state_q     <= StIdle;
         len_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         hi_q        <= '0;
         load_q      <= '0;
         addr_q      <= '0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         hi_q        <= hi_d;
         load_q      <= load_d;
         addr_q      <= addr_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign load      = load_q;
   assign ins_addr  = addr_q;
   assign cpu_reset = cpu_reset_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
